// File: rtl/jtag_stream_pkg.sv
// -----------------------------------------------------------------------------
// jtag_stream_pkg
// Shared types and helpers for the JTAG user-DR stream receiver.
//   jtag_state_e : TAP-tracking FSM states (IDLE / CAPTURED / SHIFTING)
//   frame_bits() : serial frame width, including the optional parity bit
//   even_parity(): XOR reduction over a zero-extended frame
// Optional feature macro: JTAG_STREAM_RX_PARITY_EN (adds one parity bit per frame).
// -----------------------------------------------------------------------------
package jtag_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CAPTURED  = 2'd1,
    ST_SHIFTING  = 2'd2
  } jtag_state_e;

`ifdef JTAG_STREAM_RX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Widest frame the parity helper accepts.
  localparam int MAX_FRAME_BITS = 64;

  // Frame = {parity?, valid, chan, data}.
  function automatic int frame_bits(input int data_width, input int chan_width);
    return data_width + chan_width + 1 + PARITY_BITS;
  endfunction

  // Returns 1 when the vector holds an odd number of ones.
  function automatic logic even_parity(input logic [MAX_FRAME_BITS-1:0] vec);
    return ^vec;
  endfunction

endpackage

// File: rtl/jtag_readback_sr.sv
// -----------------------------------------------------------------------------
// jtag_readback_sr
// Capture-load / shift-right / zero-fill register. Its LSB is the serial output,
// so after WIDTH shifts the output reads 0 until the next load.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : load i_din (has priority over i_shift)
//   i_shift        : shift right by one, zero fill at the MSB
//   i_din [WIDTH]  : parallel load value
//   o_sout         : current LSB
// -----------------------------------------------------------------------------
module jtag_readback_sr #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_sout
);

  logic [WIDTH-1:0] r_sr;

  // Load on capture, otherwise shift out LSB first with zero fill.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= i_din;
    end else if (i_shift) begin
      r_sr <= r_sr >> 1;
    end else begin
      r_sr <= r_sr;
    end
  end

  assign o_sout = r_sr[0];

endmodule

// File: rtl/jtag_stream_rx.sv
// -----------------------------------------------------------------------------
// jtag_stream_rx
// JTAG user-DR stream receiver clocked by tck. De-serialises a continuous TDI
// stream into frames {parity?, valid, chan, data} (LSB first) and emits one
// word per valid frame without needing an Update-DR per word. A result word is
// captured on Capture-DR and shifted out on tdo.
// Ports:
//   tck, rst_n           : JTAG clock, asynchronous active-low reset
//   test_logic_reset     : TAP in Test-Logic-Reset (synchronous clear)
//   ir_is_user           : qualifies every TAP event below
//   capture_dr/shift_dr/update_dr : TAP state decodes
//   tdi / tdo            : serial in / readback out
//   result               : value loaded into the readback register
//   out_valid/out_chan/out_data : one-cycle word strobe with channel and payload
//   frame_count          : valid frames emitted, saturating
//   partial_frame_err    : sticky, Update-DR seen mid-frame
//   parity_err_count     : frames dropped for bad parity, saturating (0 if off)
// Optional feature macro: JTAG_STREAM_RX_PARITY_EN.
// -----------------------------------------------------------------------------
module jtag_stream_rx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CHAN_WIDTH   = 2,
  parameter int RESULT_WIDTH = 32,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                    tck,
  input  logic                    rst_n,
  input  logic                    test_logic_reset,
  input  logic                    ir_is_user,
  input  logic                    capture_dr,
  input  logic                    shift_dr,
  input  logic                    update_dr,
  input  logic                    tdi,
  output logic                    tdo,
  input  logic [RESULT_WIDTH-1:0] result,
  output logic                    out_valid,
  output logic [CHAN_WIDTH-1:0]   out_chan,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [COUNT_WIDTH-1:0]  frame_count,
  output logic                    partial_frame_err,
  output logic [7:0]              parity_err_count
);

  import jtag_stream_pkg::*;

  localparam int FRAME_BITS = frame_bits(DATA_WIDTH, CHAN_WIDTH);
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int VALID_IDX  = DATA_WIDTH + CHAN_WIDTH;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  jtag_state_e             r_state;
  jtag_state_e             w_state_nxt;
  logic                    w_armed;

  logic [CNT_W-1:0]        r_bit_cnt;
  // Holds the FRAME_BITS-1 bits received so far; the completing bit comes from tdi.
  logic [FRAME_BITS-2:0]   r_frame_sr;
  logic [FRAME_BITS-1:0]   w_frame;

  logic                    w_tlr;
  logic                    w_cap;
  logic                    w_upd;
  logic                    w_shift;
  logic                    w_shift_en;
  logic                    w_frame_done;
  logic                    w_parity_ok;
  logic                    w_frame_keep;
  logic                    w_rb_sout;

  logic                    r_out_valid;
  logic [CHAN_WIDTH-1:0]   r_out_chan;
  logic [DATA_WIDTH-1:0]   r_out_data;
  logic [COUNT_WIDTH-1:0]  r_frame_count;
  logic                    r_partial_err;

  // Event decode; priority is TLR > capture > update > shift, and capture
  // beats a simultaneous shift.
  assign w_tlr   = ir_is_user & test_logic_reset;
  assign w_cap   = ir_is_user & capture_dr & ~w_tlr;
  assign w_upd   = ir_is_user & update_dr & ~w_tlr & ~w_cap;
  assign w_shift = ir_is_user & shift_dr & ~capture_dr & ~w_tlr & ~w_upd;

  // Bits only count once the DR has been captured.
  assign w_shift_en   = w_shift & w_armed;
  assign w_frame      = {tdi, r_frame_sr};
  assign w_frame_done = w_shift_en & (r_bit_cnt == LAST_BIT);

`ifdef JTAG_STREAM_RX_PARITY_EN
  assign w_parity_ok = ~even_parity(MAX_FRAME_BITS'(w_frame));
`else
  assign w_parity_ok = 1'b1;
`endif

  assign w_frame_keep = w_frame_done & w_frame[VALID_IDX] & w_parity_ok;

  // FSM state register.
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    if (w_tlr) begin
      w_state_nxt = ST_IDLE;
    end else if (w_cap) begin
      w_state_nxt = ST_CAPTURED;
    end else if (w_upd) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:     w_state_nxt = ST_IDLE;
        ST_CAPTURED: w_state_nxt = w_shift ? ST_SHIFTING : ST_CAPTURED;
        ST_SHIFTING: w_state_nxt = ST_SHIFTING;
        default:     w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: shifting is enabled in CAPTURED and SHIFTING.
  always_comb begin
    w_armed = 1'b0;
    case (r_state)
      ST_IDLE:     w_armed = 1'b0;
      ST_CAPTURED: w_armed = 1'b1;
      ST_SHIFTING: w_armed = 1'b1;
      default:     w_armed = 1'b0;
    endcase
  end

  // Bit counter and frame shifter; TLR, capture and update all realign to bit 0.
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt  <= '0;
      r_frame_sr <= '0;
    end else if (w_tlr || w_cap || w_upd) begin
      r_bit_cnt  <= '0;
      r_frame_sr <= '0;
    end else if (w_shift_en) begin
      r_frame_sr <= w_frame[FRAME_BITS-1:1];
      r_bit_cnt  <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + CNT_W'(1);
    end else begin
      r_bit_cnt  <= r_bit_cnt;
      r_frame_sr <= r_frame_sr;
    end
  end

  // Word output: strobe for one cycle, data/chan hold between strobes.
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_out_chan    <= '0;
      r_out_data    <= '0;
      r_frame_count <= '0;
    end else begin
      r_out_valid <= w_frame_keep;
      if (w_frame_keep) begin
        r_out_data <= w_frame[DATA_WIDTH-1:0];
        r_out_chan <= w_frame[VALID_IDX-1:DATA_WIDTH];
        if (r_frame_count != {COUNT_WIDTH{1'b1}}) begin
          r_frame_count <= r_frame_count + COUNT_WIDTH'(1);
        end else begin
          r_frame_count <= r_frame_count;
        end
      end else begin
        r_out_data    <= r_out_data;
        r_out_chan    <= r_out_chan;
        r_frame_count <= r_frame_count;
      end
    end
  end

  // Sticky flag: Update-DR arrived with a partially received frame.
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      r_partial_err <= 1'b0;
    end else if (w_upd && (r_bit_cnt != '0)) begin
      r_partial_err <= 1'b1;
    end else begin
      r_partial_err <= r_partial_err;
    end
  end

`ifdef JTAG_STREAM_RX_PARITY_EN
  logic [7:0] r_parity_err_cnt;

  // Count frames dropped for parity mismatch, saturating at 255.
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      r_parity_err_cnt <= 8'd0;
    end else if (w_frame_done && !w_parity_ok && (r_parity_err_cnt != 8'hFF)) begin
      r_parity_err_cnt <= r_parity_err_cnt + 8'd1;
    end else begin
      r_parity_err_cnt <= r_parity_err_cnt;
    end
  end

  assign parity_err_count = r_parity_err_cnt;
`else
  assign parity_err_count = 8'd0;
`endif

  jtag_readback_sr #(
    .WIDTH (RESULT_WIDTH)
  ) u_readback (
    .i_clk   (tck),
    .i_rst_n (rst_n),
    .i_load  (w_cap),
    .i_shift (w_shift_en),
    .i_din   (result),
    .o_sout  (w_rb_sout)
  );

  // tdo comes straight from the register so it is stable before the TAP's falling-edge sample.
  assign tdo               = ir_is_user ? w_rb_sout : 1'b0;
  assign out_valid         = r_out_valid;
  assign out_chan          = r_out_chan;
  assign out_data          = r_out_data;
  assign frame_count       = r_frame_count;
  assign partial_frame_err = r_partial_err;

endmodule
